// File: rtl/game_referee_if.sv
// game_referee_if
//   Button levels in, lights and game outcome out, for one two-player
//   reaction-time game.
//   master: drives btnStart/btnP1/btnP2, observes the outputs (button side).
//   slave : the referee; samples the buttons, drives the outputs.
//   Signals:
//     btnStart, btnP1, btnP2 : synchronized, debounced button levels
//     armedLed, goLed        : state lights
//     gameFinished           : one-cycle result pulse
//     lastWinner             : 0 = player 1, 1 = player 2
//     falseStart             : last result decided by a false start
//     reactionTicks[11:0]    : reaction time of the last legitimate win
interface game_referee_if;
   logic        btnStart;
   logic        btnP1;
   logic        btnP2;
   logic        armedLed;
   logic        goLed;
   logic        gameFinished;
   logic        lastWinner;
   logic        falseStart;
   logic [11:0] reactionTicks;

   modport master (
      output btnStart, btnP1, btnP2,
      input  armedLed, goLed, gameFinished, lastWinner, falseStart, reactionTicks
   );

   modport slave (
      input  btnStart, btnP1, btnP2,
      output armedLed, goLed, gameFinished, lastWinner, falseStart, reactionTicks
   );
endinterface

// File: rtl/game_referee.sv
// game_referee
//   Referees one reaction-time game between two players. A start press arms
//   the game; after MIN_DELAY + random(0..2^RAND_BITS-1) ticks the GO light
//   turns on. First press after GO wins, a press before GO loses.
//   Ports:
//     clk       : system clock
//     resetGame : synchronous, active-high reset
//     bus       : game_referee_if.slave (buttons in, lights/outcome out)
//   Optional build macro:
//     REFEREE_AUTO_REARM_EN : DONE re-arms by itself after 2*MIN_DELAY ticks
//                             without a start press.
module game_referee #(
   parameter int unsigned TICK_DIV  = 100000,
   parameter int unsigned MIN_DELAY = 1000,
   parameter int unsigned RAND_BITS = 10,
   parameter int unsigned TIMEOUT   = 3000,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic          clk,
   input  logic          resetGame,
   game_referee_if.slave bus
);

   localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned DLY_W = $clog2(2 * MIN_DELAY + 2 ** RAND_BITS + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARMED,
      S_GO,
      S_DONE
   } state_t;

   state_t state_q, state_d;

   logic             start_q, p1_q, p2_q;
   logic             start_e, p1_e, p2_e;
   logic [15:0]      lfsr;
   logic [PRE_W-1:0] presc;
   logic             tick;
   logic [DLY_W-1:0] delay_cnt;
   logic [DLY_W-1:0] rand_delay;
   logic [11:0]      react_cnt;
   logic             tie_break;

   logic             game_finished;
   logic             last_winner;
   logic             false_start;
   logic [11:0]      reaction_ticks;

   logic load_delay, dec_delay, inc_delay;
   logic clr_react, inc_react, upd_react;
   logic declare, win_next, fs_next, flip_tie;

   // Edge registers clear on reset, but the level history keeps sampling so
   // a button held through reset does not look like a fresh press.
   always_ff @(posedge clk) begin
      if (resetGame) begin
         start_e <= 1'b0;
         p1_e    <= 1'b0;
         p2_e    <= 1'b0;
      end else begin
         start_e <= bus.btnStart & ~start_q;
         p1_e    <= bus.btnP1 & ~p1_q;
         p2_e    <= bus.btnP2 & ~p2_q;
      end
      start_q <= bus.btnStart;
      p1_q    <= bus.btnP1;
      p2_q    <= bus.btnP2;
   end

   // 16-bit Galois LFSR, taps 16'hB400; nonzero seed keeps it off zero.
   always_ff @(posedge clk) begin
      if (resetGame) begin
         lfsr <= LFSR_SEED;
      end else if (lfsr[0]) begin
         lfsr <= (lfsr >> 1) ^ 16'hB400;
      end else begin
         lfsr <= lfsr >> 1;
      end
   end

   assign rand_delay = DLY_W'(MIN_DELAY) + DLY_W'(lfsr[RAND_BITS-1:0]);
   assign tick       = (presc == PRE_W'(TICK_DIV - 1));

   // Prescaler restarts on every state change so each state sees full ticks.
   always_ff @(posedge clk) begin
      if (resetGame) begin
         presc <= '0;
      end else if (state_d != state_q || tick) begin
         presc <= '0;
      end else begin
         presc <= presc + PRE_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (resetGame) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      load_delay = 1'b0;
      dec_delay  = 1'b0;
      inc_delay  = 1'b0;
      clr_react  = 1'b0;
      inc_react  = 1'b0;
      upd_react  = 1'b0;
      declare    = 1'b0;
      win_next   = 1'b0;
      fs_next    = 1'b0;
      flip_tie   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_e) begin
               load_delay = 1'b1;
               state_d    = S_ARMED;
            end
         end
         S_ARMED: begin
            if (p1_e && p2_e) begin
               // Simultaneous false start voids the round; re-roll the delay.
               load_delay = 1'b1;
            end else if (p1_e || p2_e) begin
               declare  = 1'b1;
               win_next = p1_e;
               fs_next  = 1'b1;
               state_d  = S_DONE;
            end else if (tick) begin
               if (delay_cnt <= DLY_W'(1)) begin
                  clr_react = 1'b1;
                  state_d   = S_GO;
               end else begin
                  dec_delay = 1'b1;
               end
            end
         end
         S_GO: begin
            if (p1_e && p2_e) begin
               declare   = 1'b1;
               win_next  = tie_break;
               flip_tie  = 1'b1;
               upd_react = 1'b1;
               state_d   = S_DONE;
            end else if (p1_e || p2_e) begin
               declare   = 1'b1;
               win_next  = p2_e;
               upd_react = 1'b1;
               state_d   = S_DONE;
            end else if (tick) begin
               if (32'(react_cnt) + 32'd1 >= TIMEOUT) begin
                  state_d = S_IDLE;
               end else begin
                  inc_react = 1'b1;
               end
            end
         end
         S_DONE: begin
            if (start_e) begin
               load_delay = 1'b1;
               state_d    = S_ARMED;
            end
`ifdef REFEREE_AUTO_REARM_EN
            else if (tick) begin
               // delay_cnt is reused as the idle-in-DONE tick counter.
               if (delay_cnt >= DLY_W'(2 * MIN_DELAY - 1)) begin
                  load_delay = 1'b1;
                  state_d    = S_ARMED;
               end else begin
                  inc_delay = 1'b1;
               end
            end
`endif
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (resetGame) begin
         delay_cnt <= '0;
      end else if (load_delay) begin
         delay_cnt <= rand_delay;
      end else if (declare) begin
         delay_cnt <= '0;
      end else if (dec_delay) begin
         delay_cnt <= delay_cnt - DLY_W'(1);
      end else if (inc_delay) begin
         delay_cnt <= delay_cnt + DLY_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (resetGame) begin
         react_cnt <= '0;
      end else if (clr_react) begin
         react_cnt <= '0;
      end else if (inc_react && react_cnt != 12'hFFF) begin
         react_cnt <= react_cnt + 12'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (resetGame) begin
         tie_break <= 1'b0;
      end else if (flip_tie) begin
         tie_break <= ~tie_break;
      end
   end

   // Result registers load on the transition into DONE, so they are valid
   // in the same cycle as the gameFinished pulse.
   always_ff @(posedge clk) begin
      if (resetGame) begin
         game_finished  <= 1'b0;
         last_winner    <= 1'b0;
         false_start    <= 1'b0;
         reaction_ticks <= '0;
      end else begin
         game_finished <= declare;
         if (declare) begin
            last_winner <= win_next;
            false_start <= fs_next;
         end
         if (upd_react) begin
            reaction_ticks <= react_cnt;
         end
      end
   end

   assign bus.armedLed      = (state_q == S_ARMED);
   assign bus.goLed         = (state_q == S_GO);
   assign bus.gameFinished  = game_finished;
   assign bus.lastWinner    = last_winner;
   assign bus.falseStart    = false_start;
   assign bus.reactionTicks = reaction_ticks;

endmodule

// File: tb/tb_game_referee.sv
// tb_game_referee
//   Bench for game_referee with TICK_DIV=4, MIN_DELAY=10, RAND_BITS=3,
//   TIMEOUT=50. Expected results are queued when player buttons are driven
//   and checked when gameFinished pulses.
module tb_game_referee;

   localparam int unsigned TD = 4;

   logic clk = 1'b0;
   logic resetGame;
   int unsigned cyc = 0;

   game_referee_if bus ();

   game_referee #(
      .TICK_DIV (4),
      .MIN_DELAY(10),
      .RAND_BITS(3),
      .TIMEOUT  (50)
   ) dut (
      .clk      (clk),
      .resetGame(resetGame),
      .bus      (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic        w;
      logic        fs;
      logic [11:0] t;
      int unsigned cyc;
   } exp_t;

   exp_t sb[$];
   int   vectors    = 0;
   int   miscompares = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Result monitor: every pulse must be single-cycle and match the queue head.
   logic prev_fin = 1'b0;
   exp_t mon_e;
   always @(negedge clk) begin
      if (bus.gameFinished === 1'b1) begin
         check("pulse_single", 32'(prev_fin), 0);
         if (sb.size() == 0) begin
            check("unexpected_pulse", 32'(sb.size()), 1);
         end else begin
            mon_e = sb.pop_front();
            check("pulse_cycle", cyc, mon_e.cyc);
            check("winner", 32'(bus.lastWinner), 32'(mon_e.w));
            check("false_start", 32'(bus.falseStart), 32'(mon_e.fs));
            check("reaction_ticks", 32'(bus.reactionTicks), 32'(mon_e.t));
         end
      end
      prev_fin = bus.gameFinished;
   end

   task automatic press_start();
      bus.btnStart = 1'b1;
      repeat (2) @(negedge clk);
      bus.btnStart = 1'b0;
   endtask

   task automatic press_players(input logic p1, input logic p2,
                                input logic w, input logic fs, input logic [11:0] t);
      exp_t e;
      e.w = w; e.fs = fs; e.t = t; e.cyc = cyc + 2;
      bus.btnP1 = p1;
      bus.btnP2 = p2;
      sb.push_back(e);
      repeat (3) @(negedge clk);
      bus.btnP1 = 1'b0;
      bus.btnP2 = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   // Returns at the first negedge with goLed high; counts armed cycles on the way.
   task automatic wait_go(output int unsigned armed_cycles);
      armed_cycles = 0;
      for (int i = 0; i < 2000 && bus.goLed !== 1'b1; i++) begin
         if (bus.armedLed === 1'b1) armed_cycles++;
         @(negedge clk);
      end
      if (bus.goLed !== 1'b1) begin
         check("wait_go_timeout", 32'(bus.goLed), 1);
      end
   endtask

   initial begin
      int unsigned ac;
      int unsigned go_cnt;
      logic [11:0] m_ticks;

      resetGame    = 1'b1;
      bus.btnStart = 1'b1;
      bus.btnP1    = 1'b1;
      bus.btnP2    = 1'b1;
      repeat (5) @(negedge clk);
      resetGame = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_armed", 32'(bus.armedLed), 0);
      check("rst_go", 32'(bus.goLed), 0);
      check("rst_fin", 32'(bus.gameFinished), 0);
      check("rst_winner", 32'(bus.lastWinner), 0);
      check("rst_fs", 32'(bus.falseStart), 0);
      check("rst_ticks", 32'(bus.reactionTicks), 0);
      bus.btnStart = 1'b0;
      bus.btnP1    = 1'b0;
      bus.btnP2    = 1'b0;
      repeat (3) @(negedge clk);
      check("idle_after_release", 32'(bus.armedLed), 0);

      // P2 wins 7 ticks after GO.
      press_start();
      wait_go(ac);
      repeat (7 * TD) @(negedge clk);
      press_players(1'b0, 1'b1, 1'b1, 1'b0, 12'd7);
      m_ticks = 12'd7;

      // P2 false start: P1 wins, reaction time kept.
      press_start();
      repeat (4) @(negedge clk);
      check("fs_armed", 32'(bus.armedLed), 1);
      press_players(1'b0, 1'b1, 1'b0, 1'b1, m_ticks);

      // Two ties in a row: tieBreak alternates 0 then 1.
      press_start();
      wait_go(ac);
      repeat (3 * TD) @(negedge clk);
      press_players(1'b1, 1'b1, 1'b0, 1'b0, 12'd3);
      press_start();
      wait_go(ac);
      repeat (5 * TD) @(negedge clk);
      press_players(1'b1, 1'b1, 1'b1, 1'b0, 12'd5);

      // Timeout: GO lasts 50 ticks, back to IDLE, outputs untouched.
      press_start();
      wait_go(ac);
      go_cnt = 0;
      for (int i = 0; i < 1000 && bus.goLed === 1'b1; i++) begin
         go_cnt++;
         @(negedge clk);
      end
      check("timeout_ticks", go_cnt / TD, 50);
      check("timeout_go", 32'(bus.goLed), 0);
      check("timeout_armed", 32'(bus.armedLed), 0);
      check("timeout_winner", 32'(bus.lastWinner), 1);
      check("timeout_fs", 32'(bus.falseStart), 0);
      check("timeout_ticks_kept", 32'(bus.reactionTicks), 5);

      // Reset while in GO.
      press_start();
      wait_go(ac);
      repeat (2) @(negedge clk);
      resetGame = 1'b1;
      @(negedge clk);
      check("midrst_go", 32'(bus.goLed), 0);
      check("midrst_armed", 32'(bus.armedLed), 0);
      check("midrst_winner", 32'(bus.lastWinner), 0);
      check("midrst_ticks", 32'(bus.reactionTicks), 0);
      resetGame = 1'b0;
      repeat (2) @(negedge clk);

      // Eight games: ARMED duration must land in 10..17 ticks.
      for (int g = 0; g < 8; g++) begin
         press_start();
         wait_go(ac);
         check("armed_range", 32'((ac / TD >= 10) && (ac / TD <= 17)), 1);
         press_players(1'b1, 1'b0, 1'b0, 1'b0, 12'd0);
      end

      repeat (5) @(negedge clk);
      check("scoreboard_empty", 32'(sb.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/game_referee.md
Name: game_referee

Overview:
- Runs one reaction-time game between two players.
- The game is armed by a start press. After a pseudo-random delay, a GO light turns on. The first player to press after GO wins; a press before GO (false start) loses.
- Produces the game-outcome interface (gameFinished pulse plus lastWinner) consumed by the match scorer, and the reaction time for display.

Parameters:
- TICK_DIV, 100000: clk cycles per game tick (1 ms at 100 MHz).
- MIN_DELAY, 1000: minimum ARMED-to-GO delay, in ticks.
- RAND_BITS, 10: number of LFSR bits added to MIN_DELAY (random range 0..2^RAND_BITS-1 ticks).
- TIMEOUT, 3000: ticks in GO with no press before the round is abandoned.
- LFSR_SEED, 16'hACE1: LFSR value on reset. Must be nonzero.

Ports:
- clk  in  1  system clock.
- resetGame  in  1  synchronous, active-high reset, sampled on rising clk.
- btnStart  in  1  start button level, already synchronized and debounced.
- btnP1  in  1  player 1 button level, already synchronized and debounced.
- btnP2  in  1  player 2 button level, already synchronized and debounced.
- armedLed  out  1  high in ARMED.
- goLed  out  1  high in GO.
- gameFinished  out  1  one-cycle pulse when a result is declared.
- lastWinner  out  1  0 = player 1, 1 = player 2. Valid from the gameFinished pulse onward.
- falseStart  out  1  1 if the last result was decided by a false start.
- reactionTicks  out  12  reaction time of the last legitimate win. Saturates at 4095.

Behaviour:
- One clock; reset is synchronous and active-high (clk, resetGame).
- Reset values:
  - FSM enters IDLE.
  - All outputs 0.
  - LFSR = LFSR_SEED; tick prescaler, delay counter, reaction counter = 0.
  - tieBreak = 0.
- Edge detection: one-cycle registered rising-edge detectors on btnStart, btnP1, btnP2. Edge registers reset to 0, so a button held through reset does not produce an edge.
- LFSR: 16-bit Galois, mask 16'hB400, steps every clk cycle, never reaches 0.
- Tick: the prescaler counts 0..TICK_DIV-1 and emits a tick when it wraps. The prescaler is cleared on every state entry.
- IDLE:
  - On a start edge, load delay = MIN_DELAY + lfsr[RAND_BITS-1:0], then go to ARMED.
- ARMED:
  - Each tick decrements delay. At 0, go to GO and clear the reaction counter.
  - Exactly one player edge (false start): the other player wins, falseStart=1, reactionTicks unchanged, go to DONE.
  - Both player edges in the same cycle: round void, no pulse. Reload delay from the current LFSR and stay in ARMED.
  - Start edges are ignored.
- GO:
  - Each tick increments the reaction counter, saturating at 4095.
  - Exactly one player edge: that player wins, falseStart=0, reactionTicks = counter, go to DONE.
  - Both player edges in the same cycle: the winner is tieBreak. tieBreak is then inverted. falseStart=0.
  - Counter reaches TIMEOUT: go to IDLE, no pulse, outputs unchanged.
- DONE:
  - gameFinished=1 for exactly the first cycle in DONE.
  - lastWinner, falseStart and reactionTicks are updated on the transition into DONE, i.e. visible in the same cycle as the pulse, and held until the next result.
  - Latency: player edge in cycle N gives the pulse in cycle N+2 (N+1 is the edge-register stage).
  - A start edge arms a new round (same path as from IDLE). Player edges are ignored.
- resetGame mid-round: return to IDLE next cycle, no pulse, outputs cleared to 0.
- goLed and armedLed are decoded from registered state (glitch-free).

Optional Feature:
- REFEREE_AUTO_REARM_EN defined:
  - DONE automatically re-arms after 2*MIN_DELAY ticks with no start edge (new random delay loaded).
  - A start edge still re-arms immediately.
- Not defined: DONE is held indefinitely until a start edge.

Test Plan:
All scenarios use TICK_DIV=4, MIN_DELAY=10, RAND_BITS=3, TIMEOUT=50.
- Reset with all buttons held high, release after 5 cycles -> all outputs 0, state IDLE, no gameFinished pulse.
- Start edge; wait for goLed; P2 edge 7 ticks later -> single gameFinished pulse 2 cycles after the edge; lastWinner=1, falseStart=0, reactionTicks=7.
- Start edge; P2 edge while armedLed=1 -> pulse; lastWinner=0, falseStart=1, reactionTicks keeps its prior value.
- In GO, P1 and P2 edges in the same cycle, twice in consecutive games -> first winner 0, second winner 1 (tieBreak alternates).
- Start edge, no presses -> goLed for 50 ticks, then IDLE; no pulse; outputs unchanged.
- resetGame asserted while in GO -> IDLE the next cycle, goLed=0, no pulse.
- ARMED delay check: across 8 games, each ARMED-to-GO duration lies in 10..17 ticks.
